// File: rtl/uart_pkg.sv
// Shared UART definitions: the FIFO entry layout and the default receive FIFO depth.
package uart_pkg;

    localparam int unsigned UART_FIFO_DEPTH = 8;
    localparam int unsigned UART_MAX_WIDTH  = 16;

    // Entries are sized for the widest supported character; narrower FIFOs leave the top bits constant.
    typedef struct packed {
        logic                      err;
        logic [UART_MAX_WIDTH-1:0] data;
    } uart_entry_t;

    function automatic uart_entry_t make_entry(input logic err, input logic [UART_MAX_WIDTH-1:0] data);
        uart_entry_t e;
        e.err  = err;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO behind a UART receiver: show-ahead head, sticky overrun, watermark and idle timeout.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned Depth = UART_FIFO_DEPTH,
    parameter int unsigned Width = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [Width-1:0]         rxData,
    input  logic                     rxDone,
    input  logic                     rxErr,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     clearOverrun,
    input  logic [$clog2(Depth):0]   threshold,
    input  logic [15:0]              timeoutCycles,
    output logic [Width-1:0]         data,
    output logic                     dataErr,
    output logic                     valid,
    output logic [$clog2(Depth):0]   count,
    output logic                     full,
    output logic                     overrun,
    output logic                     aboveThreshold,
    output logic                     timeout
);

    localparam int unsigned PW = $clog2(Depth);
    localparam int unsigned CW = PW + 1;

    uart_entry_t   mem_q [Depth];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   idle_q, idle_d;

    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [CW-1:0] thr_eff;
    uart_entry_t   head_entry;

    always_comb begin
        valid   = count_q != '0;
        full    = count_q == CW'(Depth);
        do_pop  = pop & valid & ~flush;
        // A pop frees the slot in the same cycle, so a full FIFO still accepts the byte.
        do_push = rxDone & (~full | pop) & ~flush;
        drop    = rxDone & full & ~pop & ~flush;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                head_d = head_q + PW'(1);
            end
            if (do_push) begin
                tail_d = tail_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        overrun_d = drop | (overrun_q & ~clearOverrun);

        if (rxDone || pop || flush || !valid) begin
            idle_d = '0;
        end else if (idle_q == 16'hFFFF) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 16'd1;
        end

        // Compare against the next idle value so timeout rises on the edge the counter reaches the limit.
        if (pop || flush) begin
            timeout_d = 1'b0;
        end else if (timeoutCycles != '0 && valid && idle_d == timeoutCycles) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            idle_q    <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            idle_q    <= idle_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[tail_q] <= make_entry(rxErr, UART_MAX_WIDTH'(rxData));
        end
    end

    always_comb begin
        head_entry     = mem_q[head_q];
        thr_eff        = (threshold == '0) ? CW'(1) : threshold;
        data           = valid ? Width'(head_entry.data) : '0;
        dataErr        = valid & head_entry.err;
        count          = count_q;
        overrun        = overrun_q;
        timeout        = timeout_q;
        aboveThreshold = count_q >= thr_eff;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at Depth=8, Width=8 with hand-computed expectations.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rxData;
    logic       rxDone;
    logic       rxErr;
    logic       pop;
    logic       flush;
    logic       clearOverrun;
    logic [3:0] threshold;
    logic [15:0] timeoutCycles;
    logic [7:0] data;
    logic       dataErr;
    logic       valid;
    logic [3:0] count;
    logic       full;
    logic       overrun;
    logic       aboveThreshold;
    logic       timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_rx_fifo #(.Depth(8), .Width(8)) dut (
        .clk(clk), .reset(reset), .rxData(rxData), .rxDone(rxDone), .rxErr(rxErr),
        .pop(pop), .flush(flush), .clearOverrun(clearOverrun), .threshold(threshold),
        .timeoutCycles(timeoutCycles), .data(data), .dataErr(dataErr), .valid(valid),
        .count(count), .full(full), .overrun(overrun), .aboveThreshold(aboveThreshold),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rxDone       = 1'b0;
        rxErr        = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        clearOverrun = 1'b0;
        reset        = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input logic e);
        rxData = b;
        rxErr  = e;
        rxDone = 1'b1;
        tick();
    endtask

    task automatic do_pop();
        pop = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; rxData = '0; rxDone = 1'b0; rxErr = 1'b0; pop = 1'b0;
        flush = 1'b0; clearOverrun = 1'b0; threshold = 4'd0; timeoutCycles = 16'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_data", 32'({dataErr, data}), 32'd0);
        check("rst_above", 32'(aboveThreshold), 32'd0);

        // In-order delivery of three bytes
        push(8'h41, 1'b0);
        check("p1_data", 32'(data), 32'h41);
        check("p1_valid", 32'(valid), 32'd1);
        check("p1_above_thr0", 32'(aboveThreshold), 32'd1);
        push(8'h42, 1'b0);
        push(8'h43, 1'b0);
        check("p3_count", 32'(count), 32'd3);
        threshold = 4'd3; #1;
        check("thr3_above", 32'(aboveThreshold), 32'd1);
        threshold = 4'd4; #1;
        check("thr4_above", 32'(aboveThreshold), 32'd0);
        do_pop();
        check("pop1_data", 32'(data), 32'h42);
        check("pop1_count", 32'(count), 32'd2);
        do_pop();
        check("pop2_data", 32'(data), 32'h43);
        do_pop();
        check("pop3_count", 32'(count), 32'd0);
        check("pop3_valid", 32'(valid), 32'd0);
        do_pop();
        check("pop_empty_count", 32'(count), 32'd0);

        // Overflow and overrun handling
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i), 1'b0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_overrun", 32'(overrun), 32'd0);
        push(8'h18, 1'b0);
        check("drop_count", 32'(count), 32'd8);
        check("drop_overrun", 32'(overrun), 32'd1);
        threshold = 4'd9; #1;
        check("thr9_above", 32'(aboveThreshold), 32'd0);
        threshold = 4'd8; #1;
        check("thr8_above", 32'(aboveThreshold), 32'd1);
        clearOverrun = 1'b1;
        tick();
        check("clr_overrun", 32'(overrun), 32'd0);
        clearOverrun = 1'b1;
        push(8'h19, 1'b0);
        check("clr_vs_drop", 32'(overrun), 32'd1);
        clearOverrun = 1'b1;
        tick();

        // Push and pop together while full
        pop = 1'b1;
        push(8'hAA, 1'b0);
        check("fullpp_count", 32'(count), 32'd8);
        check("fullpp_overrun", 32'(overrun), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("drain_%0d", i), 32'(data), 32'(8'h10 + i));
            do_pop();
        end
        check("drain_last", 32'(data), 32'hAA);
        do_pop();
        check("drain_empty", 32'(valid), 32'd0);

        // Error flag travels with its byte
        push(8'h55, 1'b1);
        push(8'h66, 1'b0);
        check("err_head_data", 32'(data), 32'h55);
        check("err_head_flag", 32'(dataErr), 32'd1);
        do_pop();
        check("err_next_data", 32'(data), 32'h66);
        check("err_next_flag", 32'(dataErr), 32'd0);
        do_pop();

        // Idle timeout
        timeoutCycles = 16'd10;
        push(8'h77, 1'b0);
        for (int k = 1; k <= 9; k++) tick();
        check("to_before", 32'(timeout), 32'd0);
        tick();
        check("to_at10", 32'(timeout), 32'd1);
        tick();
        check("to_sticky", 32'(timeout), 32'd1);
        do_pop();
        check("to_pop_clear", 32'(timeout), 32'd0);
        timeoutCycles = 16'd0;

        // Reset wins over a concurrent strobe
        reset = 1'b1;
        push(8'h99, 1'b0);
        check("rst_strobe_count", 32'(count), 32'd0);
        check("rst_strobe_ovr", 32'(overrun), 32'd0);

        // Set overrun, then stream across the pointer wrap and flush
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i), 1'b0);
        check("wrap_pre_ovr", 32'(overrun), 32'd1);
        for (int i = 0; i < 8; i++) do_pop();
        push(8'h70, 1'b0);
        push(8'h71, 1'b0);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_data_%0d", i), 32'(data), (i < 2) ? 32'(8'h70 + i) : 32'(8'h80 + i - 2));
            pop = 1'b1;
            push(8'(8'h80 + i), 1'b0);
        end
        check("wrap_count", 32'(count), 32'd2);
        check("wrap_head", 32'(data), 32'h92);
        flush = 1'b1;
        push(8'hEE, 1'b0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(valid), 32'd0);
        check("flush_overrun", 32'(overrun), 32'd1);
        push(8'h33, 1'b0);
        check("post_flush_data", 32'(data), 32'h33);
        check("post_flush_count", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter Depth, default 8, entry count; power of two, 2..256.
REQ-002 SHALL have parameter Width, default 8, data bits per entry.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rxData  input  Width  byte from UART receiver.
REQ-006 SHALL have port rxDone  input  1  one-cycle strobe: rxData valid this cycle.
REQ-007 SHALL have port rxErr  input  1  framing error for the byte strobed by rxDone.
REQ-008 SHALL have port pop  input  1  consumer removes head entry.
REQ-009 SHALL have port flush  input  1  discard all entries.
REQ-010 SHALL have port clearOverrun  input  1  clear sticky overrun flag.
REQ-011 SHALL have port threshold  input  $clog2(Depth)+1  watermark level.
REQ-012 SHALL have port timeoutCycles  input  16  idle-timeout length; 0 disables timeout.
REQ-013 SHALL have port data  output  Width  head entry data (show-ahead).
REQ-014 SHALL have port dataErr  output  1  head entry error flag.
REQ-015 SHALL have port valid  output  1  FIFO non-empty.
REQ-016 SHALL have port count  output  $clog2(Depth)+1  occupied entries, 0..Depth.
REQ-017 SHALL have port full  output  1  count == Depth.
REQ-018 SHALL have port overrun  output  1  sticky: byte dropped while full.
REQ-019 SHALL have port aboveThreshold  output  1  count >= threshold, with threshold 0 treated as 1.
REQ-020 SHALL have port timeout  output  1  sticky idle-timeout indication.

Function
REQ-021 SHALL store {rxErr, rxData} at tail on rxDone when not full; the entry is visible on data/dataErr/valid the next cycle (1-cycle latency, no bypass).
REQ-022 SHALL present head entry combinationally from storage; pop when valid advances head, so the next entry is visible next cycle.
REQ-023 SHALL ignore pop when valid is 0 (count stays 0, pointers unchanged).
REQ-024 SHALL on simultaneous rxDone and pop with 0 < count < Depth accept both; count unchanged.
REQ-025 SHALL on rxDone with full and pop both asserted accept the byte; count stays Depth; overrun not set.
REQ-026 SHALL on rxDone with full and no pop drop the byte and set overrun.
REQ-027 SHALL clear overrun on clearOverrun unless a drop occurs the same cycle; drop wins.
REQ-028 SHALL use wrapping pointers of $clog2(Depth) bits; wrap from Depth-1 to 0 is seamless.
REQ-029 SHALL on flush set count to 0 and reset pointers, ignore pop and rxDone that cycle, and clear timeout; overrun is unaffected.
REQ-030 SHALL keep a 16-bit idle counter: zeroed on rxDone, pop, or flush, and when empty; otherwise incremented while valid, saturating.
REQ-031 SHALL set timeout when timeoutCycles != 0, valid is 1, and the idle counter reaches timeoutCycles; timeout SHALL clear on pop or flush.
REQ-032 SHALL compute aboveThreshold combinationally from count; threshold > Depth never asserts.

Reset
REQ-033 SHALL on reset set count 0, pointers 0, overrun 0, timeout 0, and idle counter 0; valid, full, and aboveThreshold are 0, and data/dataErr read 0.
REQ-034 SHALL let reset override all inputs in the same cycle; a byte strobed during reset is lost without setting overrun.

Structure
REQ-035 SHALL take the entry struct typedef (err bit plus data) and the default depth constant from shared package uart_pkg.
REQ-036 SHALL be a single module; a sub-module is not warranted.

Verification
REQ-037 SHALL cover: 3 rxDone bytes 0x41, 0x42, 0x43 then 3 pops -> data 0x41, 0x42, 0x43 in order; count 3->0; valid falls after the last pop.
REQ-038 SHALL cover: Depth=8, 9 rxDone without pop -> full=1, count=8, overrun=1, 9th byte absent; clearOverrun -> overrun=0.
REQ-039 SHALL cover: full FIFO, rxDone with pop in the same cycle -> count stays 8, overrun=0, and the new byte is read last.
REQ-040 SHALL cover: byte 0x55 with rxErr=1 -> dataErr=1 at head; next byte with rxErr=0 -> dataErr=0 after pop.
REQ-041 SHALL cover: timeoutCycles=10, one byte, no pop -> timeout rises exactly 10 cycles after the push cycle; pop clears it.
REQ-042 SHALL cover: 20 push/pop cycles crossing pointer wrap, then flush concurrent with rxDone -> count=0, valid=0, overrun unchanged.
